// File: rtl/cmos_frame_packer.sv
// cmos_frame_packer
//   Capture-to-memory write front end on the camera pixel clock. Takes the
//   CMOS stream (vsync/href/valid/data), crops a window, keeps one frame out
//   of every frame_skip+1, and packs PACK = MEM_DATA_BITS/PIX_BITS pixels
//   per memory word. It also runs the write_req/write_req_ack handshake
//   with frame_read_write.
// Ports
//   clk            camera pixel clock (single domain)
//   rst_n          synchronous active-low reset
//   in_vsync       frame sync; a rising edge starts a frame
//   in_href        line valid
//   in_valid       pixel strobe, qualified by in_href
//   in_data        pixel value
//   frame_skip     keep 1 of every frame_skip+1 frames
//   write_req      frame write request, held until acknowledged
//   write_req_ack  request acknowledge
//   write_en       one-cycle strobe marking write_data valid
//   write_data     packed word; the first pixel sits in the low bits
//   frame_words    constant number of words in a complete frame
//   frame_done     pulses with the last write_en of a frame
//   frame_err      pulses when a frame is abandoned or truncated
module cmos_frame_packer #(
   parameter int PIX_BITS      = 16,
   parameter int MEM_DATA_BITS = 32,
   parameter int H_ACT         = 1024,
   parameter int V_ACT         = 768,
   parameter int CROP_X0       = 0,
   parameter int CROP_Y0       = 0,
   parameter int CROP_W        = 1024,
   parameter int CROP_H        = 768,
   parameter int SKIP_BITS     = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_vsync,
   input  logic                     in_href,
   input  logic                     in_valid,
   input  logic [PIX_BITS-1:0]      in_data,
   input  logic [SKIP_BITS-1:0]     frame_skip,
   output logic                     write_req,
   input  logic                     write_req_ack,
   output logic                     write_en,
   output logic [MEM_DATA_BITS-1:0] write_data,
   output logic [23:0]              frame_words,
   output logic                     frame_done,
   output logic                     frame_err
);

   localparam int PACK = MEM_DATA_BITS / PIX_BITS;
   localparam int PW   = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int XW   = $clog2(H_ACT + 1);
   localparam int YW   = $clog2(V_ACT + 1);
   localparam logic [23:0] FW = 24'(CROP_W * CROP_H / PACK);

   typedef enum logic [1:0] {IDLE, REQ, ACTIVE, DROP} state_t;

   state_t                   state_q;
   logic                     vsync_q;
   logic                     href_q;
   logic [XW-1:0]            x_q;
   logic [YW-1:0]            y_q;
   logic [PW-1:0]            pack_q;
   logic [23:0]              word_cnt_q;
   logic [SKIP_BITS-1:0]     skip_q;
   logic                     abandon_q;
   logic [MEM_DATA_BITS-1:0] pack_reg_q;
   logic                     write_req_q;
   logic                     write_en_q;
   logic [MEM_DATA_BITS-1:0] write_data_q;
   logic                     frame_done_q;
   logic                     frame_err_q;

   logic                     vs_rise;
   logic                     pix;
   logic                     in_win;
   logic [MEM_DATA_BITS-1:0] word_d;

   assign vs_rise = in_vsync & ~vsync_q;
   assign pix     = in_href & in_valid;

   // Signed compares keep a zero window origin from becoming a constant test.
   assign in_win = (int'(x_q) >= CROP_X0) && (int'(x_q) < CROP_X0 + CROP_W) &&
                   (int'(y_q) >= CROP_Y0) && (int'(y_q) < CROP_Y0 + CROP_H);

   // Completed word: the pixels gathered so far plus the current pixel on top.
   always_comb begin
      word_d = pack_reg_q;
      word_d[(PACK-1)*PIX_BITS +: PIX_BITS] = in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         pack_q       <= '0;
         word_cnt_q   <= '0;
         skip_q       <= '0;
         abandon_q    <= 1'b0;
         pack_reg_q   <= '0;
         write_req_q  <= 1'b0;
         write_en_q   <= 1'b0;
         write_data_q <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         vsync_q      <= in_vsync;
         href_q       <= in_href;
         write_en_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;

         // A new frame start is honoured everywhere except during the
         // handshake; an unfinished active frame is reported as truncated.
         if (vs_rise && state_q != REQ) begin
            if (state_q == ACTIVE) frame_err_q <= 1'b1;
            if (skip_q == '0) begin
               skip_q    <= frame_skip;
               abandon_q <= 1'b0;
               state_q   <= REQ;
            end else begin
               skip_q  <= skip_q - SKIP_BITS'(1);
               state_q <= DROP;
            end
         end else begin
            case (state_q)
               REQ: begin
                  // Pixels before the ack mean the frame start was missed.
                  if (pix && !abandon_q) begin
                     abandon_q   <= 1'b1;
                     frame_err_q <= 1'b1;
                  end
                  if (write_req_q && write_req_ack) begin
                     write_req_q <= 1'b0;
                     x_q         <= '0;
                     y_q         <= '0;
                     pack_q      <= '0;
                     word_cnt_q  <= '0;
                     state_q     <= (abandon_q || pix) ? DROP : ACTIVE;
                  end else begin
                     write_req_q <= 1'b1;
                  end
               end
               ACTIVE: begin
                  if (pix) begin
                     if (x_q != XW'(H_ACT)) x_q <= x_q + XW'(1);
                     if (in_win) begin
                        if (pack_q == PW'(PACK - 1)) begin
                           write_en_q   <= 1'b1;
                           write_data_q <= word_d;
                           pack_q       <= '0;
                           word_cnt_q   <= word_cnt_q + 24'd1;
                           if (word_cnt_q == FW - 24'd1) begin
                              frame_done_q <= 1'b1;
                              state_q      <= IDLE;
                           end
                        end else begin
                           pack_reg_q[int'(pack_q)*PIX_BITS +: PIX_BITS] <= in_data;
                           pack_q <= pack_q + PW'(1);
                        end
                     end
                  end else if (href_q && !in_href && x_q != '0) begin
                     x_q <= '0;
                     if (y_q != YW'(V_ACT)) y_q <= y_q + YW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign write_req   = write_req_q;
   assign write_en    = write_en_q;
   assign write_data  = write_data_q;
   assign frame_done  = frame_done_q;
   assign frame_err   = frame_err_q;
   assign frame_words = FW;

endmodule

// File: tb/tb_cmos_frame_packer.sv
module tb_cmos_frame_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_vsync = 1'b0;
   logic        in_href = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic [3:0]  frame_skip = '0;
   logic        write_req;
   logic        write_req_ack = 1'b0;
   logic        write_en;
   logic [31:0] write_data;
   logic [23:0] frame_words;
   logic        frame_done;
   logic        frame_err;

   always #5 clk = ~clk;

   cmos_frame_packer #(
      .PIX_BITS(16), .MEM_DATA_BITS(32), .H_ACT(8), .V_ACT(4),
      .CROP_X0(2), .CROP_Y0(1), .CROP_W(4), .CROP_H(2), .SKIP_BITS(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href),
      .in_valid(in_valid), .in_data(in_data), .frame_skip(frame_skip),
      .write_req(write_req), .write_req_ack(write_req_ack),
      .write_en(write_en), .write_data(write_data), .frame_words(frame_words),
      .frame_done(frame_done), .frame_err(frame_err)
   );

   typedef struct {
      logic [31:0] data;
      logic        done;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          vectors = 0;
   int          miscompares = 0;
   int          err_cnt = 0;
   logic [31:0] exp_words [4] = '{32'h0013_0012, 32'h0015_0014,
                                  32'h0023_0022, 32'h0025_0024};

   // Monitor: pops the scoreboard on every write strobe.
   always @(negedge clk) begin
      if (frame_err) err_cnt++;
      if (write_en) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got data=%h done=%b, required no write", write_data, frame_done);
         end else begin
            mon_e = sb.pop_front();
            if (write_data !== mon_e.data || frame_done !== mon_e.done) begin
               miscompares++;
               $display("FAIL write_word: got data=%h done=%b, required data=%h done=%b",
                        write_data, frame_done, mon_e.data, mon_e.done);
            end else begin
               $display("write ok data=%h done=%b", write_data, frame_done);
            end
         end
      end else if (frame_done) begin
         vectors++;
         miscompares++;
         $display("FAIL done_alone: frame_done=1 without write_en, required 0");
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end else begin
         $display("check %s ok (%h)", name, act);
      end
   endtask

   task automatic push_frame();
      for (int i = 0; i < 4; i++) sb.push_back('{exp_words[i], (i == 3)});
   endtask

   task automatic send_line(input int y, input int nx, input bit toggle);
      in_href = 1'b1;
      for (int x = 0; x < nx; x++) begin
         if (toggle) begin
            in_valid = 1'b0;
            in_data  = 16'hdead;
            tick();
         end
         in_valid = 1'b1;
         in_data  = 16'(y * 16 + x);
         tick();
      end
      // Line gap: valid kept high while href is low must be ignored.
      in_href  = 1'b0;
      in_valid = toggle;
      in_data  = 16'hbeef;
      for (int g = 0; g < (toggle ? 3 + y : 2); g++) tick();
      in_valid = 1'b0;
   endtask

   task automatic send_lines(input int nx, input bit toggle);
      for (int y = 0; y < 4; y++) send_line(y, nx, toggle);
   endtask

   task automatic vs_pulse();
      in_vsync = 1'b1;
      tick();
      tick();
      in_vsync = 1'b0;
      tick();
   endtask

   task automatic handshake(input bit expect_req, input bit do_ack);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         if (write_req) seen = 1'b1;
      end
      check("write_req_seen", 32'(seen), 32'(expect_req));
      if (seen && do_ack) begin
         repeat (3) tick();
         write_req_ack = 1'b1;
         tick();
         write_req_ack = 1'b0;
      end
   endtask

   task automatic run_frame(input bit expect_req, input int nx, input bit toggle);
      vs_pulse();
      handshake(expect_req, 1'b1);
      if (expect_req) push_frame();
      send_lines(nx, toggle);
      repeat (4) tick();
   endtask

   int  e0;
   bit  exp_req [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      repeat (3) tick();
      check("rst_write_req", 32'(write_req), 32'd0);
      check("rst_write_en", 32'(write_en), 32'd0);
      check("rst_write_data", write_data, 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("frame_words", 32'(frame_words), 32'd4);
      rst_n = 1'b1;
      repeat (3) tick();

      // 1: basic frame
      run_frame(1'b1, 8, 1'b0);
      check("drain_t1", 32'(sb.size()), 32'd0);

      // 2: frame decimation, keep 1 of 3
      frame_skip = 4'd2;
      for (int f = 0; f < 6; f++) run_frame(exp_req[f], 8, 1'b0);
      frame_skip = 4'd0;
      check("drain_t2", 32'(sb.size()), 32'd0);

      // 3: pixels arrive while the request is still pending
      e0 = err_cnt;
      vs_pulse();
      handshake(1'b1, 1'b0);
      send_lines(8, 1'b0);
      write_req_ack = 1'b1;
      tick();
      write_req_ack = 1'b0;
      repeat (4) tick();
      check("t3_err_count", 32'(err_cnt - e0), 32'd1);
      check("t3_req_released", 32'(write_req), 32'd0);
      run_frame(1'b1, 8, 1'b0);
      check("drain_t3", 32'(sb.size()), 32'd0);

      // 4: new frame start after two words
      vs_pulse();
      handshake(1'b1, 1'b1);
      sb.push_back('{32'h0013_0012, 1'b0});
      sb.push_back('{32'h0015_0014, 1'b0});
      send_line(0, 8, 1'b0);
      send_line(1, 8, 1'b0);
      e0 = err_cnt;
      run_frame(1'b1, 8, 1'b0);
      check("t4_err_count", 32'(err_cnt - e0), 32'd1);
      check("drain_t4", 32'(sb.size()), 32'd0);

      // 5: reset mid-line
      vs_pulse();
      handshake(1'b1, 1'b1);
      sb.push_back('{32'h0013_0012, 1'b0});
      send_line(0, 8, 1'b0);
      in_href = 1'b1;
      for (int x = 0; x < 4; x++) begin
         in_valid = 1'b1;
         in_data  = 16'(16 + x);
         tick();
      end
      rst_n   = 1'b0;
      in_data = 16'h0014;
      tick();
      rst_n = 1'b1;
      check("t5_write_req", 32'(write_req), 32'd0);
      check("t5_write_en", 32'(write_en), 32'd0);
      check("t5_write_data", write_data, 32'd0);
      check("t5_frame_done", 32'(frame_done), 32'd0);
      check("t5_frame_err", 32'(frame_err), 32'd0);
      for (int x = 5; x < 8; x++) begin
         in_data = 16'(16 + x);
         tick();
      end
      in_href  = 1'b0;
      in_valid = 1'b0;
      tick();
      send_line(2, 8, 1'b0);
      send_line(3, 8, 1'b0);
      repeat (4) tick();
      check("t5_no_req", 32'(write_req), 32'd0);
      check("drain_t5a", 32'(sb.size()), 32'd0);
      run_frame(1'b1, 8, 1'b0);
      check("drain_t5b", 32'(sb.size()), 32'd0);

      // 6: valid toggling, varied line gaps, 9th pixel per line
      run_frame(1'b1, 9, 1'b1);
      check("drain_t6", 32'(sb.size()), 32'd0);

      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
